// File: rtl/pad_attr_sequencer.sv
// Pad attribute sequencer: accepts attribute-update requests over valid/ready,
// writes a per-pad attribute bank one pad per cycle, then holds off new
// requests for a programmable settle window.
module pad_attr_sequencer #(
  parameter int unsigned          NUM_PADS      = 8,
  parameter int unsigned          PADATTR       = 16,
  parameter int unsigned          SETTLE_CYCLES = 4,
  parameter logic [PADATTR-1:0]   RESET_ATTR    = '0,
  parameter int unsigned          IDXW          = $clog2(NUM_PADS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [IDXW-1:0]             req_idx_i,
  input  logic [PADATTR-1:0]          req_attr_i,
  input  logic                        req_bcast_i,
  output logic [NUM_PADS*PADATTR-1:0] pad_attributes_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  // One counter serves both the broadcast pad walk and the settle countdown.
  localparam int unsigned CNT_MAX = (NUM_PADS > SETTLE_CYCLES) ? NUM_PADS : SETTLE_CYCLES;
  localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StApply, StSettle} state_e;

  state_e                             state_q;
  logic [CNTW-1:0]                    cnt_q;
  logic [IDXW-1:0]                    idx_q;
  logic [PADATTR-1:0]                 attr_q;
  logic                               bcast_q;
  logic                               ready_q;
  logic                               busy_q;
  logic                               done_q;
  logic                               err_q;
  logic [NUM_PADS-1:0][PADATTR-1:0]   bank_q;
  logic [IDXW-1:0]                    widx;
  logic                               idx_bad;

  // Out-of-range indices can only occur when NUM_PADS is not a power of two.
  if (NUM_PADS == (1 << IDXW)) begin : g_pow2
    assign idx_bad = 1'b0;
  end else begin : g_npow2
    assign idx_bad = (32'(req_idx_i) >= NUM_PADS);
  end

  assign widx = bcast_q ? cnt_q[IDXW-1:0] : idx_q;

  // Sequencer FSM, bank writes and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      attr_q  <= '0;
      bcast_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bank_q  <= {NUM_PADS{RESET_ATTR}};
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            if (!req_bcast_i && idx_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q <= StApply;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              idx_q   <= req_idx_i;
              attr_q  <= req_attr_i;
              bcast_q <= req_bcast_i;
            end
          end
        end
        StApply: begin
          bank_q[widx] <= attr_q;
          if (!bcast_q || (cnt_q == CNTW'(NUM_PADS - 1))) begin
            if (SETTLE_CYCLES == 0) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= StSettle;
              cnt_q   <= CNTW'(SETTLE_CYCLES - 1);
            end
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o      = ready_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign pad_attributes_o = bank_q;

endmodule

// File: tb/tb_pad_attr_sequencer.sv
// Bench for pad_attr_sequencer: two instances (8 pads / settle 4, and
// 6 pads / no settle / non-zero reset value) checked every cycle against a
// timeline model, plus directed literal checks.
module tb_pad_attr_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  valid_v;
  logic [1:0]  bcast_v;
  logic [2:0]  idx_v  [2];
  logic [15:0] attr_v [2];

  logic         ready_a, busy_a, done_a, err_a;
  logic         ready_b, busy_b, done_b, err_b;
  logic [127:0] pad_a;
  logic [95:0]  pad_b;

  pad_attr_sequencer #(
    .NUM_PADS(8), .PADATTR(16), .SETTLE_CYCLES(4), .RESET_ATTR(16'h0000)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid_v[0]), .req_ready_o(ready_a),
    .req_idx_i(idx_v[0]), .req_attr_i(attr_v[0]), .req_bcast_i(bcast_v[0]),
    .pad_attributes_o(pad_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  pad_attr_sequencer #(
    .NUM_PADS(6), .PADATTR(16), .SETTLE_CYCLES(0), .RESET_ATTR(16'h1234)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid_v[1]), .req_ready_o(ready_b),
    .req_idx_i(idx_v[1]), .req_attr_i(attr_v[1]), .req_bcast_i(bcast_v[1]),
    .pad_attributes_o(pad_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  logic [127:0] pa_v [2];
  logic [3:0]   st_v [2];
  assign pa_v[0] = pad_a;
  assign pa_v[1] = {32'h0, pad_b};
  assign st_v[0] = {ready_a, busy_a, done_a, err_a};
  assign st_v[1] = {ready_b, busy_b, done_b, err_b};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic int nof(input int d);
    return (d == 0) ? 8 : 6;
  endfunction
  function automatic int sof(input int d);
    return (d == 0) ? 4 : 0;
  endfunction
  function automatic logic [15:0] rof(input int d);
    return (d == 0) ? 16'h0000 : 16'h1234;
  endfunction

  // Timeline model: an accepted request at edge e0 writes pad k at e0+1+k
  // (or its single pad at e0+1) and completes at e0 + (bcast ? N : 1) + S.
  logic [15:0] mbank [2][8];
  bit          mact  [2];
  bit          mdone [2];
  bit          merr  [2];
  int          acc_edge [2];
  int          busy_end [2];
  logic [15:0] acc_attr [2];
  logic [2:0]  acc_idx  [2];
  bit          acc_b    [2];
  int          ec = 0;

  always @(posedge clk or negedge rst_n) begin
    int off;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 8; k++) mbank[d][k] = rof(d);
        mact[d] = 0; mdone[d] = 0; merr[d] = 0;
      end
    end else begin
      ec++;
      for (int d = 0; d < 2; d++) begin
        mdone[d] = 0;
        merr[d]  = 0;
        if (mact[d]) begin
          off = ec - acc_edge[d];
          if (acc_b[d]) begin
            if (off >= 1 && off <= nof(d)) mbank[d][off-1] = acc_attr[d];
          end else if (off == 1) begin
            mbank[d][acc_idx[d]] = acc_attr[d];
          end
          if (ec == busy_end[d]) begin
            mact[d]  = 0;
            mdone[d] = 1;
          end
        end else if (valid_v[d]) begin
          if (!bcast_v[d] && int'(idx_v[d]) >= nof(d)) begin
            merr[d] = 1;
          end else begin
            mact[d]     = 1;
            acc_edge[d] = ec;
            acc_attr[d] = attr_v[d];
            acc_idx[d]  = idx_v[d];
            acc_b[d]    = bcast_v[d];
            busy_end[d] = ec + (bcast_v[d] ? nof(d) : 1) + sof(d);
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [127:0] ev;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        ev = '0;
        for (int k = 0; k < nof(d); k++) ev[k*16 +: 16] = mbank[d][k];
        chk(d == 0 ? "model_bank_a" : "model_bank_b", pa_v[d], ev);
        chk(d == 0 ? "model_status_a" : "model_status_b", 128'(st_v[d]),
            128'({!mact[d], mact[d], mdone[d], merr[d]}));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a request and wait for it to be accepted; returns at the
  // sampling point after the accept edge with valid dropped.
  task automatic send(input int d, input logic [2:0] idx, input logic [15:0] attr,
                      input logic b);
    bit got = 0;
    @(negedge clk);
    valid_v[d] = 1'b1; idx_v[d] = idx; attr_v[d] = attr; bcast_v[d] = b;
    for (int i = 0; i < 200; i++) begin
      if (st_v[d][3]) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut %0d: got no ready want ready", d);
    end
    @(posedge clk);
    @(negedge clk);
    valid_v[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_v = '0; bcast_v = '0;
    for (int d = 0; d < 2; d++) begin
      idx_v[d] = '0; attr_v[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset values.
    chk("reset_bank_a", 128'(pad_a), 128'h0);
    chk("reset_bank_b", 128'(pad_b), 128'({6{16'h1234}}));
    chk("reset_status_a", 128'(st_v[0]), 128'(4'b1000));
    chk("reset_status_b", 128'(st_v[1]), 128'(4'b1000));

    // Single write on A, settle 4.
    send(0, 3'd3, 16'hA5A5, 1'b0);
    chk("single_ready_e0", 128'(ready_a), 128'(0));
    chk("single_pad3_e0", 128'(pad_a[48 +: 16]), 128'(16'h0000));
    step();
    chk("single_pad3_e1", 128'(pad_a[48 +: 16]), 128'(16'hA5A5));
    chk("single_pad2_e1", 128'(pad_a[32 +: 16]), 128'(16'h0000));
    repeat (3) step();
    chk("single_busy_e4", 128'({ready_a, done_a}), 128'(2'b00));
    step();
    chk("single_done_e5", 128'({ready_a, done_a}), 128'(2'b11));
    step();
    chk("single_done_e6", 128'(done_a), 128'(0));

    // Broadcast on A.
    send(0, 3'd0, 16'h00FF, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j <= 8) chk("bcast_pad_new", 128'(pad_a[(j-1)*16 +: 16]), 128'(16'h00FF));
      if (j < 8)  chk("bcast_pad_old", 128'(pad_a[j*16 +: 16]),
                      128'((j == 3) ? 16'hA5A5 : 16'h0000));
      chk("bcast_done", 128'(done_a), 128'(j == 12));
    end

    // Asynchronous reset in the middle of A's settle window.
    send(0, 3'd5, 16'h1111, 1'b0);
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_bank_a", 128'(pad_a), 128'h0);
    chk("midreset_status_a", 128'(st_v[0]), 128'(4'b1000));
    chk("midreset_bank_b", 128'(pad_b), 128'({6{16'h1234}}));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      chk("midreset_no_done", 128'(done_a), 128'(0));
    end

    // Back-to-back on B with valid held high; attr changes during APPLY.
    @(negedge clk);
    valid_v[1] = 1'b1; idx_v[1] = 3'd1; attr_v[1] = 16'hBEEF; bcast_v[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idx_v[1] = 3'd2; attr_v[1] = 16'hDEAD;
    chk("b2b_ready_e0", 128'(ready_b), 128'(0));
    step();
    chk("b2b_done_e1", 128'({done_b, ready_b}), 128'(2'b11));
    chk("b2b_pad1_e1", 128'(pad_b[16 +: 16]), 128'(16'hBEEF));
    attr_v[1] = 16'hCAFE;
    step();
    chk("b2b_accept_e2", 128'({done_b, ready_b}), 128'(2'b00));
    valid_v[1] = 1'b0; attr_v[1] = 16'h0000;
    step();
    chk("b2b_done_e3", 128'(done_b), 128'(1));
    chk("b2b_pad2_e3", 128'(pad_b[32 +: 16]), 128'(16'hCAFE));
    chk("b2b_pad1_e3", 128'(pad_b[16 +: 16]), 128'(16'hBEEF));

    // Out-of-range index on B, followed by a valid request at E1.
    @(negedge clk);
    valid_v[1] = 1'b1; idx_v[1] = 3'd7; attr_v[1] = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    chk("err_pulse_e0", 128'(st_v[1]), 128'(4'b1001));
    idx_v[1] = 3'd4; attr_v[1] = 16'h4444;
    step();
    chk("err_accept_e1", 128'({ready_b, err_b}), 128'(2'b00));
    valid_v[1] = 1'b0;
    step();
    chk("err_done_e2", 128'(done_b), 128'(1));
    chk("err_pad4", 128'(pad_b[64 +: 16]), 128'(16'h4444));
    chk("err_pad5", 128'(pad_b[80 +: 16]), 128'(16'h1234));

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        valid_v[d] = ($urandom_range(0, 1) == 1);
        bcast_v[d] = ($urandom_range(0, 7) == 0);
        idx_v[d]   = 3'($urandom_range(0, 7));
        attr_v[d]  = 16'($urandom);
      end
    end
    @(negedge clk);
    valid_v = '0;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pad_attr_sequencer.md
# pad_attr_sequencer

Sequencing controller for the pad ring's attribute inputs. It accepts attribute-update requests over a valid/ready handshake and writes them into a per-pad attribute register bank that drives the `pad_attributes_i` inputs of the pad cells. Broadcast updates are applied one pad per cycle to limit simultaneous I/O switching. Every update is followed by a programmable settle window before the next request is accepted. The block sits between the pad-control register file and the pad ring instance.

## Interface

Parameters:
- `NUM_PADS`, 8: number of controlled pads; must be ≥ 2.
- `PADATTR`, 16: attribute width per pad; matches the pad cells.
- `SETTLE_CYCLES`, 4: settle-window length in cycles; 0 is legal.
- `RESET_ATTR`, `'0`: per-pad attribute value after reset.
- `IDXW`, `$clog2(NUM_PADS)`: derived; pad-index width.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `req_valid_i`, input, 1: request valid.
- `req_ready_o`, output, 1: request ready; high only in IDLE.
- `req_idx_i`, input, IDXW: target pad index; ignored when `req_bcast_i` is high.
- `req_attr_i`, input, PADATTR: attribute value to write.
- `req_bcast_i`, input, 1: write `req_attr_i` to all pads.
- `pad_attributes_o`, output, NUM_PADS*PADATTR: attribute bank; pad k occupies bits [k*PADATTR +: PADATTR].
- `busy_o`, output, 1: high when the state is not IDLE.
- `done_o`, output, 1: one-cycle pulse when an update and its settle window complete.
- `err_o`, output, 1: one-cycle pulse when a request is rejected (index out of range).

## Operation

- FSM states:
  - IDLE: `req_ready_o`=1.
  - APPLY: writes the pad(s).
  - SETTLE: counts down the settle window.
- Accept occurs when `req_valid_i && req_ready_o` at a rising edge. `req_idx_i`, `req_attr_i` and `req_bcast_i` are latched only at accept; later changes on these inputs have no effect.
- IDLE transitions at accept:
  - Non-broadcast with `req_idx_i >= NUM_PADS`: stay in IDLE, bank unchanged, `err_o` pulses. This case is unreachable when NUM_PADS is a power of two.
  - Otherwise: go to APPLY; the internal pad counter is cleared to 0.
- APPLY, single write: lasts 1 cycle; writes the latched attribute into the latched pad index only.
- APPLY, broadcast: lasts NUM_PADS cycles; the pad counter increments from 0 to NUM_PADS-1, writing one pad per cycle in ascending order.
- Leaving APPLY: go to SETTLE with the counter loaded to SETTLE_CYCLES-1. If SETTLE_CYCLES=0, skip SETTLE and go directly to IDLE.
- SETTLE: decrement the counter each cycle. On the cycle the counter reads 0, go to IDLE and set `done_o` for the next cycle.
- Pads not addressed by a request keep their value.
- Reset, including mid-operation:
  - State goes to IDLE.
  - All bank entries go to RESET_ATTR.
  - Counters go to 0.
  - `done_o` and `err_o` go to 0.
  - Any in-flight request is dropped with no `done_o`.
- Output reset values:
  - `req_ready_o`=1
  - `busy_o`=0
  - `done_o`=0
  - `err_o`=0
  - `pad_attributes_o`={NUM_PADS{RESET_ATTR}}

## Timing

- Edge numbering: accept at edge E0; S = SETTLE_CYCLES, N = NUM_PADS.
- Single write:
  - The pad register updates at E1 and is visible from the cycle after E1.
  - SETTLE occupies cycles E1..E(1+S).
  - `done_o`=1 and `req_ready_o`=1 in the cycle after E(1+S).
  - The earliest next accept is at E(2+S).
  - With S=0: `done_o` in the cycle after E1; next accept at E2.
- Broadcast:
  - Pad k updates at edge E(1+k).
  - `done_o` pulses in the cycle after E(N+S).
  - The earliest next accept is at E(N+S+1).
- Error:
  - `err_o`=1 in the cycle after E0.
  - `req_ready_o` stays 1, so a new accept is possible at E1.
- All outputs are registered; there is no combinational path from any input to any output.
- `busy_o` is the exact complement of `req_ready_o`.
- `done_o` and `err_o` are never high in the same cycle.

## Test plan

- Reset: hold `rst_ni`=0, then release. Required: `pad_attributes_o` all RESET_ATTR, `req_ready_o`=1, `busy_o`/`done_o`/`err_o`=0. Assert `rst_ni` asynchronously mid-SETTLE: outputs return to reset values immediately and no `done_o` follows.
- Single write, S=4: accept idx=3, attr=0xA5A5 at E0. Required:
  - pad 3 = 0xA5A5 after E1; other pads unchanged.
  - `req_ready_o`=0 from after E0 until after E5.
  - `done_o` pulse in the cycle after E5.
- Broadcast, N=8, S=4: accept attr=0x00FF at E0. Required:
  - pad k = 0x00FF only from after E(1+k), checked at every edge.
  - `done_o` in the cycle after E12.
- Back-to-back, S=0: hold `req_valid_i` high with two single requests (idx 1, then idx 2). Required: accepts at E0 and E2; `done_o` after E1 and after E3. Changing `req_attr_i` during APPLY must have no effect.
- Error, NUM_PADS=6: request idx=7, non-broadcast. Required: `err_o` pulse after E0, bank unchanged, no `done_o`, and a valid request is accepted at E1.
